// File: rtl/sub_pipe_if.sv
// Handshaked operand/result bundle for the pipelined subtractor.
// The producer side drives operands and consumer readiness. The unit side
// returns input readiness and the registered result with its flags.
interface sub_pipe_if #(
  parameter int DATAWIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] diff;
  logic                 borrow;
  logic                 overflow;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, diff, borrow, overflow
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, diff, borrow, overflow
  );
endinterface

// File: rtl/sub_pipe.sv
// Pipelined, flow-controlled subtractor: diff = a - b.
// Stage 0 holds the arithmetic result and its borrow/overflow flags. The
// remaining stages only carry the result forward. Each stage has its own
// ready term, so an empty stage always accepts (bubbles collapse), and held
// data never moves while the consumer stalls.
module sub_pipe #(
  parameter int DATAWIDTH = 8,
  parameter int STAGES    = 2,
  parameter int SATURATE  = 0
) (
  input logic       Clk,
  input logic       Rst,
  sub_pipe_if.slave bus
);
  localparam int MSB = DATAWIDTH - 1;

  logic [DATAWIDTH:0] raw_s;
  logic               borrow_s;
  logic               overflow_s;
  logic [MSB:0]       res_s;
  logic [STAGES:0]    rdy_s;

  logic               vld_r [STAGES];
  logic [MSB:0]       dat_r [STAGES];
  logic               brw_r [STAGES];
  logic               ovf_r [STAGES];

  // Raw (DATAWIDTH+1)-bit difference and the flags derived from it
  always_comb begin
    raw_s      = {1'b0, bus.a} - {1'b0, bus.b};
    borrow_s   = raw_s[DATAWIDTH];
    overflow_s = (bus.a[MSB] != bus.b[MSB]) && (raw_s[MSB] != bus.a[MSB]);
  end

  // Result select: wrap modulo 2^DATAWIDTH, or clamp when saturation is built in
  always_comb begin
    res_s = raw_s[MSB:0];
    if (SATURATE != 0) begin
      if (!bus.is_signed && borrow_s) begin
        res_s = {DATAWIDTH{1'b0}};
      end else if (bus.is_signed && overflow_s && !bus.a[MSB]) begin
        res_s = {1'b0, {(DATAWIDTH-1){1'b1}}};
      end else if (bus.is_signed && overflow_s) begin
        res_s = {1'b1, {(DATAWIDTH-1){1'b0}}};
      end else begin
        res_s = raw_s[MSB:0];
      end
    end else begin
      res_s = raw_s[MSB:0];
    end
  end

  // Ready chain: a stage can load if it is empty or its successor is moving
  assign rdy_s[STAGES] = bus.out_ready;
  for (genvar g = 0; g < STAGES; g++) begin : g_rdy
    assign rdy_s[g] = ~vld_r[g] | rdy_s[g+1];
  end

  assign bus.in_ready = rdy_s[0];

  // Stage 0: capture the arithmetic result when the stage can accept
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_r[0] <= 1'b0;
      dat_r[0] <= {DATAWIDTH{1'b0}};
      brw_r[0] <= 1'b0;
      ovf_r[0] <= 1'b0;
    end else if (rdy_s[0]) begin
      vld_r[0] <= bus.in_valid;
      if (bus.in_valid) begin
        dat_r[0] <= res_s;
        brw_r[0] <= borrow_s;
        ovf_r[0] <= overflow_s;
      end else begin
        dat_r[0] <= dat_r[0];
        brw_r[0] <= brw_r[0];
        ovf_r[0] <= ovf_r[0];
      end
    end else begin
      vld_r[0] <= vld_r[0];
    end
  end

  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    // Carry stage: take the predecessor's contents whenever this stage can accept
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        vld_r[g] <= 1'b0;
        dat_r[g] <= {DATAWIDTH{1'b0}};
        brw_r[g] <= 1'b0;
        ovf_r[g] <= 1'b0;
      end else if (rdy_s[g]) begin
        vld_r[g] <= vld_r[g-1];
        dat_r[g] <= dat_r[g-1];
        brw_r[g] <= brw_r[g-1];
        ovf_r[g] <= ovf_r[g-1];
      end else begin
        vld_r[g] <= vld_r[g];
      end
    end
  end

  assign bus.out_valid = vld_r[STAGES-1];
  assign bus.diff      = dat_r[STAGES-1];
  assign bus.borrow    = brw_r[STAGES-1];
  assign bus.overflow  = ovf_r[STAGES-1];
endmodule
